// File: rtl/hash_result_buf.sv
// Result buffer behind the mur3 hash pipeline: tags each hash with a wrapping sequence number,
// queues it in a show-ahead FIFO and throttles mur3 through a registered stall.
module hash_result_buf #(
   parameter int DEPTH       = 8,
   parameter int BUCKET_BITS = 10,
   parameter int TAG_W       = 8,
   parameter int MARGIN      = 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [31:0]               i_hash_key,
   input  logic                      i_hash_valid,
   output logic                      o_stall_pipe,
   input  logic                      i_flush,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [31:0]               o_hash_key,
   output logic [BUCKET_BITS-1:0]    o_bucket,
   output logic [TAG_W-1:0]          o_tag,
   output logic [$clog2(DEPTH):0]    o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL   = LW'(DEPTH);
   localparam logic [LW-1:0] THRESH = LW'(DEPTH - MARGIN);

   logic [31:0]      key_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic [LW-1:0]    count_next;
   logic [TAG_W-1:0] tag_cnt;
   logic             wr_en;
   logic             rd_en;

   // Handshakes: a result moves from mur3 when i_hash_valid & ~o_stall_pipe (and room remains);
   // the head moves to the consumer when o_valid & i_ready, both on the rising edge.
   assign wr_en      = i_hash_valid & ~o_stall_pipe & (count != FULL);
   assign rd_en      = o_valid & i_ready;
   assign count_next = count + LW'(wr_en) - LW'(rd_en);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         tag_cnt      <= '0;
         o_stall_pipe <= 1'b0;
      end else if (i_flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         tag_cnt      <= '0;
         o_stall_pipe <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr  <= wr_ptr + AW'(1);
            tag_cnt <= tag_cnt + TAG_W'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         // Stall looks at the post-edge occupancy so mur3 sees it one cycle after the threshold write.
         o_stall_pipe <= (count_next >= THRESH);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !i_flush) begin
         key_mem[wr_ptr] <= i_hash_key;
         tag_mem[wr_ptr] <= tag_cnt;
      end
   end

   // Head fields read as zero while empty so stale storage never leaks out.
   assign o_valid    = (count != '0);
   assign o_hash_key = o_valid ? key_mem[rd_ptr] : '0;
   assign o_tag      = o_valid ? tag_mem[rd_ptr] : '0;
   assign o_bucket   = o_hash_key[BUCKET_BITS-1:0];
   assign o_level    = count;

endmodule

// File: tb/tb_hash_result_buf.sv
// Bench for hash_result_buf: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based model of the buffer.
module tb_hash_result_buf;

   localparam int DEPTH  = 8;
   localparam int BB     = 10;
   localparam int TAG_W  = 8;
   localparam int MARGIN = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]      i_hash_key = '0;
   logic             i_hash_valid = 1'b0;
   logic             i_flush = 1'b0;
   logic             i_ready = 1'b0;
   logic             o_stall_pipe;
   logic             o_valid;
   logic [31:0]      o_hash_key;
   logic [BB-1:0]    o_bucket;
   logic [TAG_W-1:0] o_tag;
   logic [3:0]       o_level;

   hash_result_buf #(.DEPTH(DEPTH), .BUCKET_BITS(BB), .TAG_W(TAG_W), .MARGIN(MARGIN)) dut (
      .clk(clk), .rstn(rstn),
      .i_hash_key(i_hash_key), .i_hash_valid(i_hash_valid), .o_stall_pipe(o_stall_pipe),
      .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
      .o_hash_key(o_hash_key), .o_bucket(o_bucket), .o_tag(o_tag), .o_level(o_level)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard / reference model ----------------
   // exp_q holds {key, tag} of every accepted result in arrival order.
   logic [39:0] exp_q[$];
   int  m_tag   = 0;
   bit  m_stall = 0;

   // producer (stands in for mur3): holds key while not accepted
   logic [31:0] p_key;
   int  p_left = 0;
   int  dut_pops = 0;
   logic [TAG_W-1:0] dut_last_tag;

   task automatic model_clear();
      exp_q.delete();
      m_tag   = 0;
      m_stall = 0;
   endtask

   task automatic model_edge(output bit accepted);
      bit wr, rd;
      accepted = 0;
      if (i_flush) begin
         model_clear();
         return;
      end
      wr = i_hash_valid && !m_stall && (exp_q.size() < DEPTH);
      rd = (exp_q.size() > 0) && i_ready;
      if (rd) void'(exp_q.pop_front());
      if (wr) begin
         exp_q.push_back({i_hash_key, 8'(m_tag)});
         m_tag    = (m_tag + 1) % (1 << TAG_W);
         accepted = 1;
      end
      m_stall = (exp_q.size() >= DEPTH - MARGIN);
   endtask

   task automatic check_vs_model();
      logic [31:0] ek;
      logic [7:0]  et;
      ek = (exp_q.size() > 0) ? exp_q[0][39:8] : 32'h0;
      et = (exp_q.size() > 0) ? exp_q[0][7:0]  : 8'h0;
      chk("valid",  64'(o_valid),      64'(exp_q.size() > 0));
      chk("level",  64'(o_level),      64'(exp_q.size()));
      chk("stall",  64'(o_stall_pipe), 64'(m_stall));
      chk("key",    64'(o_hash_key),   64'(ek));
      chk("tag",    64'(o_tag),        64'(et));
      chk("bucket", 64'(o_bucket),     64'(ek % 1024));
   endtask

   // ---------------- driver tasks ----------------
   // One modelled cycle: compare, advance model, clock, move producer on acceptance.
   task automatic step();
      bit acc;
      check_vs_model();
      if (o_valid && i_ready) begin
         dut_pops++;
         dut_last_tag = o_tag;
      end
      model_edge(acc);
      @(posedge clk);
      #1;
      if (acc) begin
         p_left--;
         p_key = $urandom();
      end
   endtask

   task automatic drive_producer();
      i_hash_valid = (p_left > 0);
      i_hash_key   = p_key;
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      i_hash_valid = 1'b0;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      model_clear();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        fl, v, rdy;
      logic [31:0] key;
      logic        e_v, e_st;
      logic [3:0]  e_lvl;
      logic [31:0] e_key;
      logic [7:0]  e_tag;
      logic [9:0]  e_bkt;
   } vec_t;
   vec_t vt[11];

   initial begin
      // fl v rdy key           e_v st lvl e_key         tag  bkt   (outputs seen before the row's edge)
      vt[0]  = '{0,1,1,32'hDEADBEEF, 0,0,0,32'h0,        0, 10'h0};
      vt[1]  = '{0,0,1,32'h0,        1,0,1,32'hDEADBEEF, 0, 10'h2EF};
      vt[2]  = '{0,1,0,32'h11111111, 0,0,0,32'h0,        0, 10'h0};
      vt[3]  = '{0,1,0,32'h22222222, 1,0,1,32'h11111111, 1, 10'h111};
      vt[4]  = '{0,1,0,32'h33333333, 1,0,2,32'h11111111, 1, 10'h111};
      vt[5]  = '{0,1,1,32'h44444444, 1,0,3,32'h11111111, 1, 10'h111};
      vt[6]  = '{0,0,0,32'h0,        1,0,3,32'h22222222, 2, 10'h222};
      vt[7]  = '{1,1,1,32'h55555555, 1,0,3,32'h22222222, 2, 10'h222};
      vt[8]  = '{0,1,0,32'h66666666, 0,0,0,32'h0,        0, 10'h0};
      vt[9]  = '{0,0,1,32'h0,        1,0,1,32'h66666666, 0, 10'h266};
      vt[10] = '{0,0,0,32'h0,        0,0,0,32'h0,        0, 10'h0};

      p_key = $urandom();

      // Test 1: reset held with a valid result presented
      i_hash_valid = 1'b1;
      i_hash_key   = 32'hA5A5A5A5;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(o_valid), 0);
      chk("rst_stall", 64'(o_stall_pipe), 0);
      chk("rst_level", 64'(o_level), 0);
      rstn = 1'b1;
      #2;
      chk("rst_release_level", 64'(o_level), 0);
      i_hash_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_idle_level", 64'(o_level), 0);

      // Tests 2 and 5 plus a flush: vector table
      for (int i = 0; i < 11; i++) begin
         i_flush = vt[i].fl; i_hash_valid = vt[i].v; i_ready = vt[i].rdy; i_hash_key = vt[i].key;
         chk($sformatf("vec%0d_valid", i),  64'(o_valid),      64'(vt[i].e_v));
         chk($sformatf("vec%0d_stall", i),  64'(o_stall_pipe), 64'(vt[i].e_st));
         chk($sformatf("vec%0d_level", i),  64'(o_level),      64'(vt[i].e_lvl));
         chk($sformatf("vec%0d_key", i),    64'(o_hash_key),   64'(vt[i].e_key));
         chk($sformatf("vec%0d_tag", i),    64'(o_tag),        64'(vt[i].e_tag));
         chk($sformatf("vec%0d_bucket", i), 64'(o_bucket),     64'(vt[i].e_bkt));
         @(posedge clk);
         #1;
      end
      i_flush = 1'b0;
      do_flush();

      // Test 3: fill with consumer stalled, then drain
      p_left = 8; i_ready = 1'b0; dut_pops = 0;
      repeat (12) begin drive_producer(); step(); end
      chk("fill_level", 64'(o_level), 7);
      chk("fill_stall", 64'(o_stall_pipe), 1);
      i_ready = 1'b1;
      repeat (14) begin drive_producer(); step(); end
      chk("fill_pops", 64'(dut_pops), 8);
      chk("fill_last_tag", 64'(dut_last_tag), 7);
      chk("fill_empty", 64'(o_valid), 0);

      // Test 6: flush while stalled at high level, then next write gets tag 0
      do_flush();
      p_left = 7; i_ready = 1'b0;
      repeat (9) begin drive_producer(); step(); end
      chk("pre_flush_stall", 64'(o_stall_pipe), 1);
      i_flush = 1'b1; i_hash_valid = 1'b1; i_ready = 1'b1;
      @(posedge clk);
      #1;
      i_flush = 1'b0;
      chk("flush_valid", 64'(o_valid), 0);
      chk("flush_level", 64'(o_level), 0);
      chk("flush_stall", 64'(o_stall_pipe), 0);
      model_clear();
      p_left = 1; i_ready = 1'b0;
      drive_producer(); step();
      chk("flush_next_tag", 64'(o_tag), 0);
      chk("flush_next_valid", 64'(o_valid), 1);
      do_flush();

      // Test 4: 300 results through with consumer always ready (tag wrap)
      p_left = 300; i_ready = 1'b1; dut_pops = 0;
      for (int c = 0; c < 1000; c++) begin
         if (p_left == 0 && exp_q.size() == 0) break;
         drive_producer(); step();
      end
      chk("wrap_pops", 64'(dut_pops), 300);
      chk("wrap_last_tag", 64'(dut_last_tag), 43);
      do_flush();

      // Randomized run: random producer gaps, consumer stalls and rare flushes
      p_left = 1 << 30;
      for (int c = 0; c < 3000; c++) begin
         // mur3 must hold a presented result until it is accepted
         if (!(i_hash_valid && m_stall)) i_hash_valid = ($urandom_range(0, 3) != 0);
         i_hash_key = p_key;
         i_ready    = ($urandom_range(0, 2) != 0) ? (c % 400 > 150) : ($urandom_range(0, 1) == 1);
         i_flush    = ($urandom_range(0, 199) == 0);
         step();
      end
      i_flush = 1'b0;
      check_vs_model();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
